// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and branch/jump redirect.
// Optional perf counters (fetch_count, flush_count) enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_eq,
  input  logic        branch_neq,
  input  logic        jump,
  input  logic        alu_zero,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid,
  output logic [5:0]  opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetchStateT;

  fetchStateT  stateReg;
  logic        reqReg;
  logic [31:0] addrReg;
  logic [31:0] targetReg;
  logic [31:0] skidReg;
  logic [31:0] instrReg;
  logic [31:0] pcPlus4Reg;
  logic        validReg;

  logic        takeBranch;
  logic        redirect;
  logic        accept;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] redirectTarget;

  always_comb begin
    takeBranch     = (branch_eq & alu_zero) | (branch_neq & ~alu_zero);
    redirect       = validReg & ~stall & (takeBranch | jump);
    branchTarget   = pcPlus4Reg + {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
    jumpTarget     = {pcPlus4Reg[31:28], instrReg[25:0], 2'b00};
    redirectTarget = jump ? jumpTarget : branchTarget;
    // A new word enters IF/ID either straight from memory or from the skid buffer.
    accept         = ~stall & ~redirect &
                     (((stateReg == FETCH) & imem_ack) | (stateReg == HOLD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg   <= FETCH;
      reqReg     <= 1'b1;
      addrReg    <= RESET_PC;
      targetReg  <= RESET_PC;
      skidReg    <= 32'h0;
      instrReg   <= 32'h0;
      pcPlus4Reg <= 32'h0;
      validReg   <= 1'b0;
    end else begin
      // IF/ID update: bubble on redirect or when decode drains it with nothing new.
      if (redirect) begin
        instrReg <= 32'h0;
        validReg <= 1'b0;
      end else if (accept) begin
        instrReg   <= (stateReg == HOLD) ? skidReg : imem_rdata;
        pcPlus4Reg <= addrReg + 32'd4;
        validReg   <= 1'b1;
      end else if (!stall) begin
        instrReg <= 32'h0;
        validReg <= 1'b0;
      end

      case (stateReg)
        FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              addrReg <= redirectTarget;
            end else begin
              targetReg <= redirectTarget;
              stateReg  <= DRAIN;
            end
          end else if (imem_ack) begin
            if (stall) begin
              skidReg  <= imem_rdata;
              reqReg   <= 1'b0;
              stateReg <= HOLD;
            end else begin
              addrReg <= addrReg + 32'd4;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            addrReg  <= redirectTarget;
            reqReg   <= 1'b1;
            stateReg <= FETCH;
          end else if (!stall) begin
            addrReg  <= addrReg + 32'd4;
            reqReg   <= 1'b1;
            stateReg <= FETCH;
          end
        end
        DRAIN: begin
          // The stale request must complete before the target can be requested.
          if (imem_ack) begin
            addrReg  <= targetReg;
            stateReg <= FETCH;
          end
        end
        default: stateReg <= FETCH;
      endcase
    end
  end

  assign imem_req     = reqReg;
  assign imem_addr    = addrReg;
  assign instr_out    = instrReg;
  assign pc_plus4_out = pcPlus4Reg;
  assign instr_valid  = validReg;
  assign opcode       = instrReg[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCntReg;
  logic [31:0] flushCntReg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchCntReg <= 32'h0;
      flushCntReg <= 32'h0;
    end else begin
      if (accept)   fetchCntReg <= fetchCntReg + 32'd1;
      if (redirect) flushCntReg <= flushCntReg + 32'd1;
    end
  end

  assign fetch_count = fetchCntReg;
  assign flush_count = flushCntReg;
`endif

endmodule
